// File: rtl/if_prefetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_buf
// Purpose  : Sequential instruction fetch into a credit-controlled prefetch
//            FIFO, handed to decode via valid/ready; flush redirects fetch.
//            Optional macro IF_PREFETCH_BYPASS_EN forwards a returning word
//            straight to decode when the FIFO is empty.
// Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_buf #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o,
  input  logic              id_ready_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]   C_DEPTH = DEPTH[CNT_W:0];

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_inflight;
  logic [CNT_W-1:0]  r_cnt;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [DATA_W-1:0] r_inst_mem [DEPTH];

  logic [CNT_W:0]    w_credit;
  logic              w_issue;
  logic              w_resp;
  logic              w_nonempty;
  logic              w_byp_valid;
  logic              w_byp_take;
  logic              w_push;
  logic              w_pop;

  // Buffered plus in-flight words never exceed DEPTH, so every response has a slot.
  assign w_credit   = {1'b0, r_cnt} + {{CNT_W{1'b0}}, r_inflight};
  assign w_issue    = rst & ~flush_i & (w_credit < C_DEPTH);
  assign w_resp     = r_inflight & ~flush_i;
  assign w_nonempty = (r_cnt != '0);

`ifdef IF_PREFETCH_BYPASS_EN
  assign w_byp_valid = w_resp & ~w_nonempty;
`else
  assign w_byp_valid = 1'b0;
`endif

  assign w_byp_take = w_byp_valid & id_ready_i;
  assign w_push     = w_resp & ~w_byp_take;
  assign w_pop      = w_nonempty & id_ready_i & ~flush_i;

  assign rom_ce_o   = w_issue;
  assign rom_addr_o = r_pc;

  always_comb begin
    id_valid_o = 1'b0;
    id_pc_o    = '0;
    id_inst_o  = '0;
    if (w_nonempty) begin
      id_valid_o = 1'b1;
      id_pc_o    = r_pc_mem[r_rd_ptr];
      id_inst_o  = r_inst_mem[r_rd_ptr];
    end else if (w_byp_valid) begin
      id_valid_o = 1'b1;
      id_pc_o    = r_req_pc;
      id_inst_o  = rom_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_cnt      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (flush_i) begin
      r_pc       <= new_pc_i;
      r_inflight <= 1'b0;
      r_cnt      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc     <= r_pc + ADDR_W'(4);
        r_req_pc <= r_pc;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_req_pc;
      r_inst_mem[r_wr_ptr] <= rom_data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_prefetch_buf
// Purpose  : Directed scoreboard bench for if_prefetch_buf; ROM returns addr>>2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_buf;

  logic        clk;
  logic        rst;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_ready_i;
  logic        flush_i;
  logic [31:0] new_pc_i;

`ifdef IF_PREFETCH_BYPASS_EN
  localparam logic [31:0] BYP_V = 32'd1;
`else
  localparam logic [31:0] BYP_V = 32'd0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  if_prefetch_buf dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_o   (rom_ce_o),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i),
    .id_valid_o (id_valid_o),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o),
    .id_ready_i (id_ready_i),
    .flush_i    (flush_i),
    .new_pc_i   (new_pc_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: word index registered one cycle after an accepted request.
  always @(posedge clk) begin
    if (rom_ce_o) rom_data_i <= rom_addr_o >> 2;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  task automatic exp_push(input logic [31:0] pc);
    q.push_back('{pc: pc, inst: pc >> 2});
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flush_pulse(input logic [31:0] pc);
    flush_i  = 1'b1;
    new_pc_i = pc;
    @(posedge clk);
    #1;
    flush_i  = 1'b0;
  endtask

  // Starts at the first issue cycle after reset release or flush with an empty FIFO.
  task automatic stream(input logic [31:0] base);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i < 4) check("stream_addr", rom_addr_o, base + 32'(4 * i));
      if (i == 0) check("stream_ce0", 32'(rom_ce_o), 32'd1);
      if (i == 0) check("latency_valid_c0", 32'(id_valid_o), 32'd0);
      if (i == 1) check("latency_valid_c1", 32'(id_valid_o), BYP_V);
      if (i == 2) check("latency_valid_c2", 32'(id_valid_o), 32'd1);
      @(posedge clk);
      #1;
      if (q.size() == 0) id_ready_i = 1'b0;
    end
    check("stream_drained", 32'(q.size()), 32'd0);
  endtask

  task automatic drain(output int ncyc);
    ncyc = 0;
    id_ready_i = 1'b1;
    while (q.size() != 0 && ncyc < 30) begin
      @(posedge clk);
      #1;
      ncyc++;
    end
    id_ready_i = 1'b0;
    check("drain_done", 32'(q.size()), 32'd0);
  endtask

  // Monitor: every accepted head word must match the scoreboard in order.
  always @(negedge clk) begin
    if (rst) begin
      if (id_valid_o && id_ready_i && !flush_i) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_delivery: got pc %0h, expected none", id_pc_o);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("deliver_pc", id_pc_o, e.pc);
          check("deliver_inst", id_inst_o, e.inst);
        end
      end else if (!id_valid_o) begin
        check("idle_pc_zero", id_pc_o, 32'd0);
        check("idle_inst_zero", id_inst_o, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_ce;
    int ncyc;
    rst        = 1'b0;
    id_ready_i = 1'b0;
    flush_i    = 1'b0;
    new_pc_i   = 32'd0;

    // Reset state and first stream
    repeat (2) @(posedge clk);
    #1;
    check("reset_ce", 32'(rom_ce_o), 32'd0);
    check("reset_valid", 32'(id_valid_o), 32'd0);
    check("reset_pc", id_pc_o, 32'd0);
    check("reset_inst", id_inst_o, 32'd0);
    check("reset_addr", rom_addr_o, 32'd0);
    exp_push(32'd0);
    exp_push(32'd4);
    exp_push(32'd8);
    id_ready_i = 1'b1;
    rst        = 1'b1;
    stream(32'd0);

    // Long stall: exactly DEPTH requests, then drain with no gaps
    flush_pulse(32'd0);
    n_ce = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rom_ce_o) n_ce++;
      @(posedge clk);
      #1;
    end
    check("stall_req_count", 32'(n_ce), 32'd4);
    @(negedge clk);
    check("full_ce", 32'(rom_ce_o), 32'd0);
    check("full_valid", 32'(id_valid_o), 32'd1);
    check("full_head_pc", id_pc_o, 32'd0);
    check("full_head_inst", id_inst_o, 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) exp_push(32'(4 * i));
    drain(ncyc);
    check("drain_cycles", 32'(ncyc), 32'd5);

    // Full FIFO, single-cycle pops, push and pop together
    wait_cyc(2);
    @(negedge clk);
    check("refull_ce", 32'(rom_ce_o), 32'd0);
    check("refull_head", id_pc_o, 32'd20);
    @(posedge clk);
    #1;
    exp_push(32'd20);
    id_ready_i = 1'b1;
    @(posedge clk);
    #1;
    id_ready_i = 1'b0;
    @(negedge clk);
    check("refill_ce", 32'(rom_ce_o), 32'd1);
    check("refill_addr", rom_addr_o, 32'd36);
    check("refill_head", id_pc_o, 32'd24);
    @(posedge clk);
    #1;
    exp_push(32'd24);
    id_ready_i = 1'b1;
    @(negedge clk);
    check("pushpop_ce", 32'(rom_ce_o), 32'd0);
    check("pushpop_valid", 32'(id_valid_o), 32'd1);
    @(posedge clk);
    #1;
    id_ready_i = 1'b0;
    @(negedge clk);
    check("after_pushpop_ce", 32'(rom_ce_o), 32'd1);
    check("after_pushpop_addr", rom_addr_o, 32'd40);
    check("after_pushpop_head", id_pc_o, 32'd28);
    @(posedge clk);
    #1;
    exp_push(32'd28);
    exp_push(32'd32);
    exp_push(32'd36);
    drain(ncyc);

    // Flush with 3 buffered and 1 in flight
    flush_pulse(32'h40);
    wait_cyc(3);
    @(negedge clk);
    check("preflush_ce", 32'(rom_ce_o), 32'd1);
    check("preflush_addr", rom_addr_o, 32'h4C);
    check("preflush_head", id_pc_o, 32'h40);
    @(posedge clk);
    #1;
    flush_i  = 1'b1;
    new_pc_i = 32'h100;
    @(negedge clk);
    check("flush_ce", 32'(rom_ce_o), 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("postflush_valid", 32'(id_valid_o), 32'd0);
    check("postflush_addr", rom_addr_o, 32'h100);
    check("postflush_ce", 32'(rom_ce_o), 32'd1);
    @(posedge clk);
    #1;
    exp_push(32'h100);
    exp_push(32'h104);
    drain(ncyc);

    // Address wrap
    exp_push(32'hFFFF_FFF8);
    exp_push(32'hFFFF_FFFC);
    exp_push(32'h0);
    id_ready_i = 1'b1;
    flush_pulse(32'hFFFF_FFF8);
    stream(32'hFFFF_FFF8);

    // Asynchronous reset with 2 buffered and 1 in flight
    flush_pulse(32'h200);
    wait_cyc(3);
    check("prereset_valid", 32'(id_valid_o), 32'd1);
    rst = 1'b0;
    #1;
    check("async_ce", 32'(rom_ce_o), 32'd0);
    check("async_valid", 32'(id_valid_o), 32'd0);
    check("async_pc", id_pc_o, 32'd0);
    check("async_inst", id_inst_o, 32'd0);
    check("async_addr", rom_addr_o, 32'd0);
    @(posedge clk);
    #1;
    exp_push(32'd0);
    exp_push(32'd4);
    exp_push(32'd8);
    id_ready_i = 1'b1;
    rst        = 1'b1;
    stream(32'd0);

    check("final_queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
